// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit batcher: FSM state type and default sizing.
package uart_pkg;

  localparam int DEPTH_DEF         = 8;
  localparam int DATA_W_DEF        = 8;
  localparam int FLUSH_TIMEOUT_DEF = 1024;
  localparam int LEVEL_W           = 4;

  typedef enum logic [1:0] {
    FILL        = 2'd0,
    ACCEPT      = 2'd1,
    DRAIN_START = 2'd2,
    DRAIN_WAIT  = 2'd3
  } batch_state_e;

endpackage

// File: rtl/uart_tx_batch_buf.sv
// Batch storage: DEPTH x DATA_W register array, synchronous write, asynchronous read.
module uart_tx_batch_buf
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_tx_batcher.sv
// Collects bytes into batches of DEPTH and feeds them one at a time to a UART transmitter.
// Optional idle flush of a partial batch when UART_TX_BATCH_TIMEOUT_EN is defined.
//
// state       | meaning
// FILL        | accepting bytes until the batch is full
// ACCEPT      | one-cycle write acknowledge; held request is ignored
// DRAIN_START | waiting for an idle transmitter, or batch emptied
// DRAIN_WAIT  | o_tx_start held until the transmitter consumes it
module uart_tx_batcher
  import uart_pkg::*;
#(
  parameter int DEPTH         = DEPTH_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_valid,
  input  logic [DATA_W-1:0]  i_wr_data,
  output logic               o_wr_clear,
  output logic [DATA_W-1:0]  o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_clear_req,
  input  logic               i_tx_busy,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_draining
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

  if (DEPTH < 2 || DEPTH > 15 || FLUSH_TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_batcher: DEPTH must be 2..15 and FLUSH_TIMEOUT >= 1");
  end

  batch_state_e       state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               tx_start_q, tx_start_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               full_q, empty_q;
  logic               we;
  logic [DATA_W-1:0]  rd_data;
  logic               batch_done;
  logic               idle_expired;

  uart_tx_batch_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_buf (
    .clk     (clk),
    .i_we    (we),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (i_wr_data),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (rd_data)
  );

  // Level and pointer equality agree whenever the batch has been fully drained.
  assign batch_done = (level_q == '0) && (rd_ptr_q == wr_ptr_q);

`ifdef UART_TX_BATCH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d       = '0;
    idle_expired = 1'b0;
    if (state_q == FILL && !i_wr_valid && level_q != '0 && level_q != LEVEL_FULL) begin
      idle_d = idle_q + 1'b1;
      if (idle_d == IDLE_W'(FLUSH_TIMEOUT)) begin
        idle_expired = 1'b1;
        idle_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign idle_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    we         = 1'b0;
    unique case (state_q)
      FILL: begin
        if (level_q == LEVEL_FULL) begin
          state_d = DRAIN_START;
        end else if (i_wr_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          level_d  = level_q + 1'b1;
          state_d  = ACCEPT;
        end else if (idle_expired) begin
          state_d = DRAIN_START;
        end
      end
      ACCEPT: state_d = FILL;
      DRAIN_START: begin
        if (batch_done) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = FILL;
        end else if (!i_tx_busy) begin
          tx_data_d  = rd_data;
          tx_start_d = 1'b1;
          state_d    = DRAIN_WAIT;
        end
      end
      DRAIN_WAIT: begin
        if (i_tx_clear_req) begin
          tx_start_d = 1'b0;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          level_d    = level_q - 1'b1;
          state_d    = DRAIN_START;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      full_q     <= (level_d == LEVEL_FULL);
      empty_q    <= (level_d == '0);
    end
  end

  assign o_wr_clear = (state_q == ACCEPT);
  assign o_draining = (state_q != FILL);
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_level    = level_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;

endmodule

// File: tb/tb_uart_tx_batcher.sv
// Directed + randomized bench for uart_tx_batcher; a byte queue models the expected transmit order.
module tb_uart_tx_batcher;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int FT     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_wr_valid;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_clear;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_start;
  logic              i_tx_clear_req;
  logic              i_tx_busy;
  logic [3:0]        o_level;
  logic              o_full;
  logic              o_empty;
  logic              o_draining;

  uart_tx_batcher #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FLUSH_TIMEOUT(FT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_wr_valid     (i_wr_valid),
    .i_wr_data      (i_wr_data),
    .o_wr_clear     (o_wr_clear),
    .o_tx_data      (o_tx_data),
    .o_tx_start     (o_tx_start),
    .i_tx_clear_req (i_tx_clear_req),
    .i_tx_busy      (i_tx_busy),
    .o_level        (o_level),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_draining     (o_draining)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until acknowledged, as the Wishbone requester does.
  task automatic write_byte(input logic [7:0] b);
    int k;
    k = 0;
    i_wr_valid = 1'b1;
    i_wr_data  = b;
    do begin
      tick();
      k++;
    end while (!o_wr_clear && k < 200);
    check("wr_clear", 32'(o_wr_clear), 32'd1);
    i_wr_valid = 1'b0;
    exp_q.push_back(b);
    check("wr_level", 32'(o_level), 32'(exp_q.size()));
  endtask

  // Transmitter model: consumes n requests, clearing each after a random delay.
  task automatic drain_n(input int n, input int dmin, input int dmax, input bit to_end,
                         output int clears);
    logic [7:0] eb, held;
    int k, d;
    bit stable;
    clears = 0;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!o_tx_start && k < 300) begin
        tick();
        k++;
        if (o_wr_clear) clears++;
      end
      check("tx_start", 32'(o_tx_start), 32'd1);
      eb = 8'h00;
      if (exp_q.size() > 0) eb = exp_q.pop_front();
      check("tx_data", 32'(o_tx_data), 32'(eb));
      held   = o_tx_data;
      stable = 1'b1;
      d      = int'($urandom_range(dmax, dmin));
      repeat (d - 1) begin
        tick();
        if (o_tx_data !== held || o_tx_start !== 1'b1) stable = 1'b0;
        if (o_wr_clear) clears++;
      end
      check("tx_hold", 32'(stable), 32'd1);
      i_tx_clear_req = 1'b1;
      tick();
      i_tx_clear_req = 1'b0;
      check("tx_drop", 32'(o_tx_start), 32'd0);
      if (o_wr_clear) clears++;
    end
    if (to_end) begin
      k = 0;
      while (o_draining && k < 50) begin
        tick();
        k++;
        if (o_wr_clear) clears++;
      end
      check("drain_end", 32'(o_draining), 32'd0);
      check("drain_level", 32'(o_level), 32'd0);
      check("drain_empty", 32'(o_empty), 32'd1);
    end
  endtask

  initial begin
    int clears, k, lat, starts, drn;
    rst_n          = 1'b0;
    i_wr_valid     = 1'b0;
    i_wr_data      = '0;
    i_tx_clear_req = 1'b0;
    i_tx_busy      = 1'b0;
    repeat (3) tick();
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_wr_clear", 32'(o_wr_clear), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_draining", 32'(o_draining), 32'd0);
    rst_n = 1'b1;
    tick();

    // 0x41..0x48, transmitter clears 20 cycles after each start
    for (int i = 0; i < 8; i++) write_byte(8'(8'h41 + i));
    check("b1_full", 32'(o_full), 32'd1);
    drain_n(8, 20, 20, 1'b1, clears);
    check("b1_no_clear", 32'(clears), 32'd0);

    // held request: exactly one acknowledge over 10 cycles
    i_wr_valid = 1'b1;
    i_wr_data  = 8'h55;
    clears     = 0;
    repeat (10) begin
      tick();
      if (o_wr_clear) begin
        clears++;
        i_wr_valid = 1'b0;
      end
    end
    i_wr_valid = 1'b0;
    exp_q.push_back(8'h55);
    check("hold_clears", 32'(clears), 32'd1);
    check("hold_level", 32'(o_level), 32'(exp_q.size()));

    // 9th write arrives while the batch drains
    for (int i = 0; i < 7; i++) write_byte(8'($urandom));
    i_wr_valid = 1'b1;
    i_wr_data  = 8'h99;
    drain_n(8, 1, 6, 1'b1, clears);
    check("bp_no_clear", 32'(clears), 32'd0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!o_wr_clear && k < 10);
    check("bp_accept", 32'(o_wr_clear), 32'd1);
    i_wr_valid = 1'b0;
    exp_q.push_back(8'h99);
    check("bp_level", 32'(o_level), 32'd1);

    // transmitter busy for 50 cycles at DRAIN_START; stray clear_req ignored
    i_tx_busy = 1'b1;
    for (int i = 0; i < 7; i++) write_byte(8'($urandom));
    tick();
    tick();
    starts = 0;
    for (int i = 0; i < 50; i++) begin
      i_tx_clear_req = (i == 10);
      tick();
      if (o_tx_start) starts++;
    end
    i_tx_clear_req = 1'b0;
    check("busy_no_start", 32'(starts), 32'd0);
    check("busy_level", 32'(o_level), 32'd8);
    check("busy_draining", 32'(o_draining), 32'd1);
    i_tx_busy = 1'b0;
    tick();
    check("busy_release_start", 32'(o_tx_start), 32'd1);
    drain_n(8, 1, 8, 1'b1, clears);

    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) write_byte(8'($urandom));
      drain_n(8, 1, 6, 1'b1, clears);
    end

    // partial batch then idle
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
`ifdef UART_TX_BATCH_TIMEOUT_EN
    lat = 0;
    while (!o_tx_start && lat < 100) begin
      tick();
      lat++;
    end
    check("flush_latency_ok", 32'(lat >= 16 && lat <= 20), 32'd1);
    drain_n(3, 1, 4, 1'b1, clears);
`else
    drn = 0;
    repeat (40) begin
      tick();
      if (o_draining) drn++;
    end
    check("idle_no_drain", 32'(drn), 32'd0);
    check("idle_level", 32'(o_level), 32'd3);
    for (int i = 0; i < 5; i++) write_byte(8'($urandom));
    drain_n(8, 1, 4, 1'b1, clears);
`endif

    // reset during DRAIN_WAIT of byte 4
    for (int i = 0; i < 8; i++) write_byte(8'(8'hA0 + i));
    drain_n(3, 20, 20, 1'b0, clears);
    k = 0;
    while (!o_tx_start && k < 50) begin
      tick();
      k++;
    end
    check("rd_fourth_start", 32'(o_tx_start), 32'd1);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_tx_start", 32'(o_tx_start), 32'd0);
    check("rd_wr_clear", 32'(o_wr_clear), 32'd0);
    check("rd_tx_data", 32'(o_tx_data), 32'd0);
    check("rd_empty", 32'(o_empty), 32'd1);
    check("rd_full", 32'(o_full), 32'd0);
    check("rd_level", 32'(o_level), 32'd0);
    check("rd_draining", 32'(o_draining), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    starts = 0;
    repeat (60) begin
      tick();
      if (o_tx_start) starts++;
    end
    check("rd_no_start_after", 32'(starts), 32'd0);
    check("rd_level_after", 32'(o_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_batcher.md
UART_TX_BATCHER -- requirements
Module: uart_tx_batcher

Interface
REQ-001 SHALL have parameter DEPTH, default 8, batch size in bytes (2..15).
REQ-002 SHALL have parameter DATA_W, default 8, byte width.
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 1024, idle cycles before a partial batch drains.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk input 1, rst_n input 1.
REQ-005 i_wr_valid  input  1  byte-write request from the Wishbone control block, level-held until cleared.
REQ-006 i_wr_data  input  DATA_W  byte to enqueue.
REQ-007 o_wr_clear  output  1  one-cycle pulse: byte accepted, requester drops i_wr_valid.
REQ-008 o_tx_data  output  DATA_W  byte presented to the transmitter.
REQ-009 o_tx_start  output  1  transmit request, held until i_tx_clear_req.
REQ-010 i_tx_clear_req  input  1  transmitter pulse: request consumed.
REQ-011 i_tx_busy  input  1  transmitter shifting a frame.
REQ-012 o_level  output  4  stored byte count.
REQ-013 o_full, o_empty  output  1 each  o_level==DEPTH, o_level==0.
REQ-014 o_draining  output  1  high outside FILL.

Function
REQ-015 SHALL implement FSM states FILL, ACCEPT, DRAIN_START, DRAIN_WAIT.
REQ-016 FILL: i_wr_valid with level<DEPTH -> write i_wr_data at wr_ptr, level+1, go ACCEPT.
REQ-017 ACCEPT: assert o_wr_clear for exactly this cycle, ignore i_wr_valid, return FILL (one-cycle gap so the held request is not written twice).
REQ-018 FILL: level==DEPTH -> DRAIN_START on the next edge; a write in that cycle SHALL not be accepted.
REQ-019 DRAIN_START: level==0 -> reset pointers, go FILL; else if !i_tx_busy -> drive o_tx_data=mem[rd_ptr], assert o_tx_start, go DRAIN_WAIT; else stay.
REQ-020 DRAIN_WAIT: o_tx_start and o_tx_data held stable; on i_tx_clear_req -> drop o_tx_start next cycle, rd_ptr+1, level-1, go DRAIN_START.
REQ-021 Bytes SHALL be transmitted in write order; no byte dropped or duplicated.
REQ-022 Outside FILL, i_wr_valid SHALL be backpressured (no o_wr_clear); the request stays pending and is accepted on the first FILL cycle.
REQ-023 Pointers SHALL be log2(DEPTH)-bit-plus-wrap, reset to 0 on every return to FILL.
REQ-024 i_tx_clear_req outside DRAIN_WAIT SHALL be ignored.
REQ-025 o_level, o_full, o_empty SHALL be registered and reflect state after the current edge.

Reset
REQ-026 rst_n low SHALL asynchronously force FILL, pointers 0, level 0, o_tx_start 0, o_wr_clear 0, o_tx_data 0, o_empty 1, o_full 0, o_draining 0.
REQ-027 Reset mid-drain SHALL discard stored bytes; no o_tx_start after release until a new batch completes.

Configuration
REQ-028 Macro UART_TX_BATCH_TIMEOUT_EN: when defined, an idle counter increments each FILL cycle with 0<level<DEPTH and no write; at FLUSH_TIMEOUT it forces DRAIN_START; any accepted write resets it to 0.
REQ-029 Without UART_TX_BATCH_TIMEOUT_EN: no counter logic; drain only on full batch.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state typedef, default DEPTH, DATA_W and FLUSH_TIMEOUT constants.
REQ-031 Storage SHALL be one sub-module uart_tx_batch_buf (DEPTH x DATA_W register array, synchronous write, asynchronous read); FSM and counters stay in uart_tx_batcher.

Verification
REQ-032 Write 0x41..0x48 (8 bytes), transmitter clears 20 cycles after each start -> 8 o_tx_start pulses, o_tx_data 0x41..0x48 in order, level returns 0, state FILL.
REQ-033 i_wr_valid held 10 cycles with 0x55 in FILL -> exactly one o_wr_clear, level=1.
REQ-034 9th write 0x99 arriving while draining -> no o_wr_clear until drain completes, then accepted as first byte of next batch.
REQ-035 i_tx_busy high at DRAIN_START for 50 cycles -> o_tx_start stays 0, then asserts on the cycle after busy falls.
REQ-036 With UART_TX_BATCH_TIMEOUT_EN, FLUSH_TIMEOUT=16, write 3 bytes then idle -> drain begins 16 cycles after last accept, 3 bytes sent; without macro -> no drain.
REQ-037 rst_n low during DRAIN_WAIT of byte 4 -> outputs at reset values immediately, o_empty=1, no further o_tx_start.
